hazard_stall_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS core. It sits beside the forwarding unit.
- Covers the hazards forwarding cannot resolve:
  - load-use stalls;
  - stalls behind the multi-cycle mult/div unit;
  - control flushes on a taken branch.
- Drives the PC write enable, the IF/ID write enable and flush, and the ID/EX bubble select.
- Contains the FSM and counter that track mult/div occupancy.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/md_busy_tracker.sv | 58 +++++
 rtl/hazard_stall_ctrl.sv | 93 +++++++++
 tb/tb_hazard_stall_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard/stall controller
// Purpose: state enum for the mult/div occupancy FSM plus default widths.
// Ports: none (package).
// Optional feature macro used by the bundle: HAZARD_PERF_CNT_EN.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int REG_W_DEFAULT  = 5;
  localparam int MD_LAT_DEFAULT = 4;
  localparam int CNT_W_DEFAULT  = 32;

  // Counter width for the default latency; instances derive their own from MD_LAT.
  localparam int MD_CNT_W = $clog2(MD_LAT_DEFAULT + 1);

endpackage

// File: rtl/md_busy_tracker.sv
// rtl/md_busy_tracker.sv - mult/div occupancy FSM and countdown
// Purpose: raises mdBusy for exactly MD_LAT cycles starting the cycle after mdStart.
// Ports:
//   clk     in  pipeline clock
//   reset   in  asynchronous active-high reset
//   mdStart in  mult/div issue (in EX this cycle)
//   mdBusy  out mult/div unit occupied
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic mdStart,
  output logic mdBusy
);

  localparam int CW = $clog2(MD_LAT + 1);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // mdStart while busy cannot happen (the ID stall holds mult/div ops back);
  // if it does, it is simply ignored and the running countdown continues.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (mdStart) begin
          state_d = MD_BUSY;
          cnt_d   = CW'(MD_LAT - 1);
        end
      end
      MD_BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else             state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    mdBusy = (state_q == MD_BUSY);
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use / mult-div stall and branch flush controller
// Purpose: drives PC/IF-ID enables, IF/ID flush and ID/EX bubble for the 5-stage core.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   idExMemRead, idExRt             load in EX and its destination
//   ifIdRs, ifIdRt, ifIdUsesRt      source specifiers of the ID instruction
//   ifIdMdOp, mdStart               mult/div op in ID, mult/div issue in EX
//   branchTaken                     taken branch/jump resolved in EX
//   pcWrite, ifIdWrite, ifIdFlush   fetch-side controls
//   idExBubble, mdBusy              bubble select, mult/div occupancy
//   stallCount                      stall-cycle counter
// Macro HAZARD_PERF_CNT_EN: when defined, stallCount counts stall cycles
// (saturating); otherwise it is tied to zero.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W  = REG_W_DEFAULT,
  parameter int MD_LAT = MD_LAT_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             idExMemRead,
  input  logic [REG_W-1:0] idExRt,
  input  logic [REG_W-1:0] ifIdRs,
  input  logic [REG_W-1:0] ifIdRt,
  input  logic             ifIdUsesRt,
  input  logic             ifIdMdOp,
  input  logic             mdStart,
  input  logic             branchTaken,
  output logic             pcWrite,
  output logic             ifIdWrite,
  output logic             ifIdFlush,
  output logic             idExBubble,
  output logic             mdBusy,
  output logic [CNT_W-1:0] stallCount
);

  logic load_use;
  logic md_stall;
  logic stall;

  md_busy_tracker #(.MD_LAT(MD_LAT)) u_md (
    .clk     (clk),
    .reset   (reset),
    .mdStart (mdStart),
    .mdBusy  (mdBusy)
  );

  // $zero is never a real producer, so it never creates a hazard.
  assign load_use = idExMemRead && (idExRt != '0) &&
                    ((idExRt == ifIdRs) || (ifIdUsesRt && (idExRt == ifIdRt)));
  assign md_stall = mdBusy && ifIdMdOp;
  assign stall    = load_use || md_stall;

  // A taken branch wins over any stall: the stalled ID instruction is wrong-path.
  always_comb begin
    pcWrite    = 1'b1;
    ifIdWrite  = 1'b1;
    ifIdFlush  = 1'b0;
    idExBubble = 1'b0;
    if (reset) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      ifIdFlush  = 1'b1;
      idExBubble = 1'b1;
    end else if (branchTaken) begin
      ifIdFlush  = 1'b1;
      idExBubble = 1'b1;
    end else if (stall) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExBubble = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (stall && !branchTaken && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stallCount = cnt_q;
`else
  assign stallCount = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

  localparam int REG_W  = 5;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             idExMemRead;
  logic [REG_W-1:0] idExRt, ifIdRs, ifIdRt;
  logic             ifIdUsesRt, ifIdMdOp, mdStart, branchTaken;
  logic             pcWrite, ifIdWrite, ifIdFlush, idExBubble, mdBusy;
  logic [CNT_W-1:0] stallCount;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.REG_W(REG_W), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .idExMemRead (idExMemRead),
    .idExRt      (idExRt),
    .ifIdRs      (ifIdRs),
    .ifIdRt      (ifIdRt),
    .ifIdUsesRt  (ifIdUsesRt),
    .ifIdMdOp    (ifIdMdOp),
    .mdStart     (mdStart),
    .branchTaken (branchTaken),
    .pcWrite     (pcWrite),
    .ifIdWrite   (ifIdWrite),
    .ifIdFlush   (ifIdFlush),
    .idExBubble  (idExBubble),
    .mdBusy      (mdBusy),
    .stallCount  (stallCount)
  );

  always @(negedge clk) begin
    if (!reset) begin
      assert (!(mdStart && mdBusy)) else $error("mdStart issued while mult/div unit busy");
    end
  end

  typedef struct packed {
    logic             pc;
    logic             ifw;
    logic             fl;
    logic             bub;
    logic             busy;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  typedef struct packed {
    logic             mr;
    logic [REG_W-1:0] ert;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             urt;
    logic             mop;
    logic             br;
    logic             e_pc;
    logic             e_ifw;
    logic             e_fl;
    logic             e_bub;
  } vec_t;

  int checks = 0;
  int passed = 0;

  // Reference model: cycles of mult/div occupancy left, and stall cycles seen.
  int          busy_left = 0;
  logic [31:0] perf = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef HAZARD_PERF_CNT_EN
    return perf;
`else
    return 32'd0;
`endif
  endfunction

  // Applies one cycle of inputs (called at posedge+1), checks all outputs
  // against the model mid-cycle, then advances the model across the edge.
  task automatic cycle(input string name, input logic mr, input logic [REG_W-1:0] ert,
                       input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                       input logic urt, input logic mop, input logic mst, input logic br,
                       output obs_t o);
    logic busy, lu, st, e_pc, e_ifw, e_fl, e_bub;
    idExMemRead = mr;  idExRt = ert;   ifIdRs = rs;   ifIdRt = rt;
    ifIdUsesRt  = urt; ifIdMdOp = mop; mdStart = mst; branchTaken = br;
    #3;
    busy = (busy_left > 0);
    lu   = mr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
    st   = lu || (busy && mop);
    if (br)      {e_pc, e_ifw, e_fl, e_bub} = 4'b1111;
    else if (st) {e_pc, e_ifw, e_fl, e_bub} = 4'b0001;
    else         {e_pc, e_ifw, e_fl, e_bub} = 4'b1100;
    o = '{pc: pcWrite, ifw: ifIdWrite, fl: ifIdFlush, bub: idExBubble, busy: mdBusy, cnt: stallCount};
    chk({name, ".mdBusy"},     32'(mdBusy),     32'(busy));
    chk({name, ".pcWrite"},    32'(pcWrite),    32'(e_pc));
    chk({name, ".ifIdWrite"},  32'(ifIdWrite),  32'(e_ifw));
    chk({name, ".ifIdFlush"},  32'(ifIdFlush),  32'(e_fl));
    chk({name, ".idExBubble"}, 32'(idExBubble), 32'(e_bub));
    chk({name, ".stallCount"}, stallCount,      exp_cnt());
    @(posedge clk);
    if (busy_left > 0) busy_left--;
    else if (mst)      busy_left = MD_LAT;
    if (st && !br && (perf != 32'hFFFF_FFFF)) perf++;
    #1;
  endtask

  task automatic idle(input string name, output obs_t o);
    cycle(name, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, o);
  endtask

  vec_t vecs[8];
  obs_t o;

  initial begin
    vecs[0] = '{1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 5'd8, 5'd2, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 5'd8, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    reset = 1'b1;
    idExMemRead = 1'b0; idExRt = '0; ifIdRs = '0; ifIdRt = '0;
    ifIdUsesRt = 1'b0; ifIdMdOp = 1'b0; mdStart = 1'b0; branchTaken = 1'b0;
    #12;
    chk("reset.pcWrite",    32'(pcWrite),    32'd0);
    chk("reset.ifIdWrite",  32'(ifIdWrite),  32'd0);
    chk("reset.ifIdFlush",  32'(ifIdFlush),  32'd1);
    chk("reset.idExBubble", 32'(idExBubble), 32'd1);
    chk("reset.mdBusy",     32'(mdBusy),     32'd0);
    chk("reset.stallCount", stallCount,      32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Table of single-cycle hazard patterns (mult/div idle).
    for (int i = 0; i < 8; i++) begin
      cycle($sformatf("vec%0d", i), vecs[i].mr, vecs[i].ert, vecs[i].rs, vecs[i].rt,
            vecs[i].urt, vecs[i].mop, 1'b0, vecs[i].br, o);
      chk($sformatf("vec%0d.tbl", i), 32'({o.pc, o.ifw, o.fl, o.bub}),
          32'({vecs[i].e_pc, vecs[i].e_ifw, vecs[i].e_fl, vecs[i].e_bub}));
    end

    // Load-use stalls only for the cycle the load sits in EX.
    idle("lu_after", o);
    chk("lu_after.pcWrite", 32'(o.pc), 32'd1);

    // Mult/div occupancy: busy exactly MD_LAT cycles, mult/div op in ID held until release.
    cycle("md_issue", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, o);
    for (int k = 0; k <= MD_LAT; k++) begin
      cycle($sformatf("md_occ%0d", k), 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, o);
      chk($sformatf("md_occ%0d.busy", k),  32'(o.busy), 32'(k < MD_LAT));
      chk($sformatf("md_occ%0d.stall", k), 32'(o.pc),   32'(k >= MD_LAT));
    end

    // Branch during MD_BUSY flushes but leaves the countdown running.
    cycle("mdbr_issue", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, o);
    cycle("mdbr_br", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, o);
    chk("mdbr_br.outs", 32'({o.pc, o.ifw, o.fl, o.bub, o.busy}), 32'b11111);
    for (int k = 1; k <= MD_LAT; k++) begin
      idle($sformatf("mdbr_tail%0d", k), o);
      chk($sformatf("mdbr_tail%0d.busy", k), 32'(o.busy), 32'(k < MD_LAT));
    end

    // Asynchronous reset while busy: mdBusy and frozen outputs react between edges.
    cycle("ar_issue", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, o);
    idle("ar_busy", o);
    chk("ar_busy.busy", 32'(o.busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar.mdBusy", 32'(mdBusy), 32'd0);
    chk("ar.frozen", 32'({pcWrite, ifIdWrite, ifIdFlush, idExBubble}), 32'b0011);
    chk("ar.stallCount", stallCount, 32'd0);
    busy_left = 0;
    perf      = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    cycle("ar_run", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, o);
    chk("ar_run.nostall", 32'({o.busy, o.pc}), 32'b01);

    // One load-use stall plus MD_LAT mult/div stalls.
    cycle("pc_lu", 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, o);
    cycle("pc_md", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, o);
    for (int k = 0; k < MD_LAT; k++)
      cycle($sformatf("pc_wait%0d", k), 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, o);
    idle("pc_end", o);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf.total", o.cnt, 32'd5);
`else
    chk("perf.total", o.cnt, 32'd0);
`endif

    // Randomized traffic against the model; mdStart only when the unit is free.
    for (int n = 0; n < 400; n++) begin
      logic mst;
      mst = (busy_left == 0) && ($urandom_range(0, 3) == 0);
      cycle($sformatf("rnd%0d", n),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            mst, 1'($urandom_range(0, 7) == 0), o);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
